// File: rtl/fifo_stream_pkg.sv
// ============================================================================
// Module   : fifo_stream_pkg
// Brief    : Shared constants, types and helpers for the FIFO stream drain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_stream_pkg;

    localparam int BUF_DEPTH = 3;

    typedef logic [1:0] occ_t;

    // Beat counter width, never narrower than one bit.
    function automatic int beat_w(input int pkt_len);
        return (pkt_len <= 2) ? 1 : $clog2(pkt_len);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_buf3.sv
// ============================================================================
// Module   : stream_buf3
// Brief    : Three-entry circular buffer with occupancy, reset-cleared storage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_buf3
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output occ_t                  occ
);

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [1:0]            r_wr_idx;
    logic [1:0]            r_rd_idx;
    occ_t                  r_occ;

    // Indices count 0,1,2 and wrap; value 3 is never reached.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_idx <= 2'd0;
            r_rd_idx <= 2'd0;
            r_occ    <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_idx] <= push_data;
                r_wr_idx        <= next_idx(r_wr_idx);
            end
            if (pop) begin
                r_rd_idx <= next_idx(r_rd_idx);
            end
            case ({push, pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_comb begin
        head_data = r_mem[0];
        case (r_rd_idx)
            2'd1:    head_data = r_mem[1];
            2'd2:    head_data = r_mem[2];
            default: head_data = r_mem[0];
        endcase
    end

    assign occ = r_occ;

endmodule

`default_nettype wire

// File: rtl/fifo_stream_drain.sv
// ============================================================================
// Module   : fifo_stream_drain
// Brief    : Drains a synchronous FIFO into a framed valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_stream_drain
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  pkt_done
);

    localparam int                BEAT_W      = beat_w(PKT_LEN);
    localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(PKT_LEN - 1);
    localparam logic [2:0]        C_CREDITS   = 3'(BUF_DEPTH);

    logic              r_pending;
    logic [BEAT_W-1:0] r_beat;
    logic              r_pkt_done;

    occ_t              w_occ;
    logic [2:0]        w_inflight;
    logic              w_rd_accept;
    logic              w_pop;

    stream_buf3 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (r_pending),
        .push_data (fifo_dout),
        .pop       (w_pop),
        .head_data (m_data),
        .occ       (w_occ)
    );

    // Credits count words already buffered plus the one still in the FIFO's
    // output register, so the sink's ready never reaches the read request.
    assign w_inflight  = {1'b0, w_occ} + {2'b00, r_pending};
    assign fifo_rd_en  = !rst && !fifo_empty && (w_inflight < C_CREDITS);
    assign w_rd_accept = fifo_rd_en && !fifo_empty;

    assign m_valid  = (w_occ != 2'd0);
    assign w_pop    = m_valid && m_ready;
    assign m_last   = (r_beat == C_LAST_BEAT);
    assign pkt_done = r_pkt_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending  <= 1'b0;
            r_beat     <= '0;
            r_pkt_done <= 1'b0;
        end else begin
            r_pending  <= w_rd_accept;
            r_pkt_done <= w_pop && m_last;
            if (w_pop) begin
                r_beat <= (r_beat == C_LAST_BEAT) ? '0 : r_beat + 1'b1;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        w_inflight <= C_CREDITS);

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_drain.sv
// ============================================================================
// Module   : tb_fifo_stream_drain
// Brief    : Scoreboard bench for fifo_stream_drain (PKT_LEN 4 and 1 builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_stream_drain;

    localparam int DW = 8;
    localparam int PL = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout  = '0;
    logic          fifo_rd_en, m_valid, m_last, pkt_done;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;

    logic          f1_empty = 1'b1;
    logic [DW-1:0] f1_dout  = '0;
    logic          f1_rd_en, m1_valid, m1_last, pkt1_done;
    logic [DW-1:0] m1_data;
    logic          m1_ready = 1'b1;

    fifo_stream_drain #(.DATA_WIDTH(DW), .PKT_LEN(PL)) u_dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data),
        .m_last(m_last), .m_ready(m_ready), .pkt_done(pkt_done)
    );

    fifo_stream_drain #(.DATA_WIDTH(DW), .PKT_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .fifo_empty(f1_empty), .fifo_dout(f1_dout),
        .fifo_rd_en(f1_rd_en), .m_valid(m1_valid), .m_data(m1_data),
        .m_last(m1_last), .m_ready(m1_ready), .pkt_done(pkt1_done)
    );

    logic [DW-1:0] q[$];
    logic [DW-1:0] q1[$];
    exp_t          exp_q[$];
    exp_t          exp1_q[$];

    int vectors = 0, errors = 0;
    int wcnt = 0, n_rd = 0, n_pop = 0, n_pd = 0, n_pd1 = 0, cyc = 0;
    int first_pop = -1, last_pop = -1;
    logic exp_pd = 1'b0, exp_pd1 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [DW-1:0] d);
        q.push_back(d);
        exp_q.push_back(exp_t'{data: d, last: ((wcnt % PL) == PL - 1)});
        wcnt++;
    endtask

    task automatic wr1(input logic [DW-1:0] d);
        q1.push_back(d);
        exp1_q.push_back(exp_t'{data: d, last: 1'b1});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        exp1_q.delete();
        wcnt      = 0;
        first_pop = -1;
        last_pop  = -1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout_left", exp_q.size() + exp1_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Registered-flag FIFO models sharing rst with the DUTs
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            fifo_dout  <= '0;
            fifo_empty <= 1'b1;
            n_rd = 0;
        end else begin
            if (fifo_rd_en && !fifo_empty) begin
                fifo_dout <= q.pop_front();
                n_rd++;
            end
            fifo_empty <= (q.size() == 0);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q1.delete();
            f1_dout  <= '0;
            f1_empty <= 1'b1;
        end else begin
            if (f1_rd_en && !f1_empty) f1_dout <= q1.pop_front();
            f1_empty <= (q1.size() == 0);
        end
    end

    // Monitors: pop the scoreboard on each handshake, check framing pulses
    always @(negedge clk) begin
        if (rst) begin
            exp_pd = 1'b0;
            n_pop  = 0;
            n_pd   = 0;
        end else begin
            exp_t e;
            cyc++;
            check("pkt_done", pkt_done, exp_pd);
            if (pkt_done) n_pd++;
            check("inflight_le3", ((n_rd - n_pop) <= 3) ? 1 : 0, 1);
            exp_pd = 1'b0;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0h, scoreboard empty", m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("m_data", m_data, e.data);
                    check("m_last", m_last, e.last);
                    exp_pd = e.last;
                end
                n_pop++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_pd1 = 1'b0;
            n_pd1   = 0;
        end else begin
            exp_t e;
            check("pkt1_done", pkt1_done, exp_pd1);
            if (pkt1_done) n_pd1++;
            exp_pd1 = 1'b0;
            if (m1_valid && m1_ready) begin
                if (exp1_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_beat1: got data %0h, scoreboard empty", m1_data);
                end else begin
                    e = exp1_q.pop_front();
                    check("m1_data", m1_data, e.data);
                    check("m1_last", m1_last, e.last);
                    exp_pd1 = e.last;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int t;
        int sent;
        logic [DW-1:0] d;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_pkt_done", pkt_done, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single word: valid two edges after the empty flag falls
        m_ready = 1'b1;
        wr(8'hA5);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (fifo_empty && t < 10);
        @(negedge clk);
        check("single_valid_early", m_valid, 0);
        @(negedge clk);
        check("single_valid", m_valid, 1);
        check("single_data", m_data, 8'hA5);
        check("single_last", m_last, 0);
        wait_drain(50);
        check("single_reads", n_rd, 1);
        check("single_pkts", n_pd, 0);

        // Full rate, 16 words back to back
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) wr(8'(i));
        wait_drain(100);
        check("fullrate_span", last_pop - first_pop, 15);
        check("fullrate_pkts", n_pd, 4);

        // Backpressure: ready low for 10 cycles
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(8'h30 + 8'(i));
        repeat (10) begin
            @(negedge clk);
            if (m_valid) check("bp_hold_data", m_data, 8'h30);
        end
        check("bp_reads", n_rd, 3);
        check("bp_valid", m_valid, 1);
        @(posedge clk);
        #1 m_ready = 1'b1;
        wait_drain(100);
        check("bp_total_reads", n_rd, 8);
        check("bp_pkts", n_pd, 2);

        // Reset in the middle of a packet
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) wr(8'h50 + 8'(i));
        t = 0;
        while (n_pop < 2 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("midrst_reach_2_beats", (n_pop >= 2) ? 1 : 0, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_rd_en", fifo_rd_en, 0);
        check("midrst_valid", m_valid, 0);
        check("midrst_data", m_data, 0);
        check("midrst_last", m_last, 0);
        check("midrst_pkt_done", pkt_done, 0);
        exp_q.delete();
        wcnt = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) wr(8'h60 + 8'(i));
        wait_drain(50);
        check("midrst_pkts", n_pd, 1);

        // Random handshake, 1000 words
        do_reset();
        sent = 0;
        while (sent < 1000) begin
            @(posedge clk);
            #1 m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                d = sent[7:0] ^ 8'h5A;
                wr(d);
                sent++;
            end
        end
        m_ready = 1'b1;
        wait_drain(5000);
        check("rand_pkts", n_pd, 250);

        // PKT_LEN=1 build: every beat is last
        do_reset();
        for (int i = 0; i < 3; i++) wr1(8'hC0 + 8'(i));
        wait_drain(50);
        check("len1_pkts", n_pd1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_stream_drain.md
# fifo_stream_drain

Downstream companion to the synchronous FIFO. It drains the FIFO through its `rd_en`/`dout`/`empty` port and re-presents the data as a valid/ready stream with packet framing. Data is registered and appears one cycle after each accepted read. A 3-entry output buffer with read credits hides that latency, so the block sustains one word per cycle with no combinational path from `m_ready` to `rd_en`.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: word width; must match the FIFO.
- `PKT_LEN`, default 4: words per packet, ≥1; `m_last` marks word `PKT_LEN` of each packet.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_dout` in `DATA_WIDTH`: FIFO read data, registered in the FIFO on an accepted read.
- `fifo_rd_en` out 1: read request to the FIFO.
- `m_valid` out 1: stream word valid.
- `m_data` out `DATA_WIDTH`: stream word.
- `m_last` out 1: last word of a packet; qualified by `m_valid`.
- `m_ready` in 1: sink accepts the word when `m_valid && m_ready`.
- `pkt_done` out 1: one-cycle pulse registered after the last word of a packet is accepted.

## Operation
- **Read accept:** a read is accepted at an edge iff `fifo_rd_en && !fifo_empty` at that edge.
  - `pending` is set at that edge.
  - At the next edge, `fifo_dout` is written into the buffer tail and `pending` clears, unless another read is accepted at the same edge.
- **Credit rule:** `fifo_rd_en = !fifo_empty && (occ + pending) < 3`.
  - `occ` is buffer occupancy, 0..3, 2 bits.
  - The rule uses registered state only. `m_ready` never enters it.
- **Buffer:** 3-entry circular buffer with `wr_idx`/`rd_idx`, each wrapping 2→0. A sum of 2 or 3 does not wrap; a lone 2'd3 from `occ` is legal.
- **Occupancy update:** push = `pending`; pop = `m_valid && m_ready`.
  - Push and pop together: `occ` unchanged, both indices advance.
  - Pop of the word pushed in the same cycle is impossible, because the push lands at the edge.
- **Output:** `m_valid = (occ != 0)`; `m_data = buf[rd_idx]`.
  - `m_data`/`m_last` stay stable while `m_valid && !m_ready`.
- **Overflow:** the credit rule guarantees `occ + pending ≤ 3`, so an overflow can never occur. Assert this in simulation.
- **Beat counter:** `beat`, width `max(1,$clog2(PKT_LEN))`.
  - Increments on each pop and wraps from `PKT_LEN-1` to 0.
  - `m_last = (beat == PKT_LEN-1)`. For `PKT_LEN=1`, `m_last` is constantly 1 whenever `m_valid`.
- **pkt_done:** registered as `pop && m_last`.
- **No FSM beyond the counters:** the effective state is (`occ`, `pending`, `beat`).

## Timing
- **Reset values:** `fifo_rd_en`=0 (forced while `rst`); `m_valid`=0; `m_data`=0; `m_last`=0 when `PKT_LEN>1`; `pkt_done`=0; `occ`=0; `pending`=0; indices=0; `beat`=0.
  - Buffer contents are reset to 0.
- **Latency:** read accepted at edge E → word written at edge E+1 → `m_valid` high during cycle E+1..E+2.
  - First word appears 2 edges after `fifo_empty` falls, given the buffer is empty.
- **Throughput:** with `m_ready` held at 1 and the FIFO non-empty, one word per cycle indefinitely; steady state is `occ`=1, `pending`=1.
- **Backpressure:** with `m_ready`=0, reads stop once `occ + pending` = 3. No data is dropped and no extra reads are issued.
- **FIFO goes empty:** reads stop at the first edge where `fifo_empty`=1. Buffered words still drain.
- **Reset mid-operation:** all state clears asynchronously.
  - An in-flight (`pending`) word is discarded.
  - A partial packet's beat count restarts at 0.
  - The FIFO shares `rst`, so no stale data remains.

## Structure
- **Package `fifo_stream_pkg`:** holds `BUF_DEPTH=3`, the `occ_t` 2-bit typedef, and a function `beat_w(PKT_LEN)` returning `max(1,$clog2(PKT_LEN))`.
- **Sub-module `stream_buf3`:** the 3-entry circular buffer.
  - Ports: push, push_data, pop, head_data, occ.
  - Credit logic and packet framing stay in `fifo_stream_drain`.

## Test plan
- **Single word:** reset, write 0xA5 into the FIFO, `m_ready`=1 → `fifo_rd_en` for exactly one accepted edge; `m_valid` 2 edges later with `m_data`=0xA5, `m_last`=0; `pkt_done` stays 0.
- **Full rate:** stream 0x00..0x0F back-to-back with `m_ready`=1, `PKT_LEN`=4.
  - Required: 16 consecutive beats, in order, with no bubbles after the first.
  - `m_last` on 0x03, 0x07, 0x0B and 0x0F; four `pkt_done` pulses.
- **Backpressure:** fill the FIFO with 8 words, hold `m_ready`=0 for 10 cycles → exactly 3 reads accepted; `m_data`=first word throughout. Release `m_ready` → remaining 8 words arrive in order, none lost or duplicated.
- **Random handshake:** random `m_ready` (50%), random writes, 1000 words → scoreboard matches in order; `occ + pending` ≤ 3 every cycle; `m_last` every 4th accepted beat.
- **Reset mid-packet:** assert `rst` after 2 beats of a packet with `pending`=1.
  - Required: all outputs at reset values immediately.
  - After release, a new 4-word packet gives `m_last` on its 4th beat.
- **`PKT_LEN`=1 build:** 3 words → `m_last`=1 and `pkt_done` pulse on every beat.
